// File: rtl/xorshift_gen_array.sv
// Multi-channel xorshift transaction source: CH_NB independent generators, each
// emitting TRANS_NB values over valid/ready, with sticky per-channel and aggregate done.
module xorshift_gen_array #(
    parameter int          CH_NB     = 4,
    parameter int          DATA_W    = 64,
    parameter int          TRANS_NB  = 16,
    parameter logic [63:0] SEED_BASE = 64'd1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CH_NB-1:0]          data_rdy,
    output logic [CH_NB-1:0]          data_vld,
    output logic [CH_NB*DATA_W-1:0]   data,
    output logic [CH_NB-1:0]          transactions_done,
    output logic                      all_done
);

    localparam int CNT_W = (TRANS_NB > 0) ? (($clog2(TRANS_NB + 1) > 0) ? $clog2(TRANS_NB + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TRANS_NB > 0) ? CNT_W'(TRANS_NB - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("xorshift_gen_array: DATA_W must be 32 or 64");
        end
        if (CH_NB < 1 || CH_NB > 32) begin : g_bad_ch
            $error("xorshift_gen_array: CH_NB must be in 1..32");
        end
    endgenerate

    // One xorshift step; the triple differs between the 32- and 64-bit variants.
    function automatic logic [DATA_W-1:0] xs_next(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] t;
        t = x;
        if (DATA_W == 32) begin
            t = t ^ (t << 13);
            t = t ^ (t >> 17);
            t = t ^ (t << 5);
        end else begin
            t = t ^ (t << 13);
            t = t ^ (t >> 7);
            t = t ^ (t << 17);
        end
        return t;
    endfunction

    genvar i;
    generate
        for (i = 0; i < CH_NB; i++) begin : g_ch
            localparam logic [DATA_W-1:0] SEED_RAW = DATA_W'(SEED_BASE + 64'(i) + 64'd1);
            localparam logic [DATA_W-1:0] SEED     = (SEED_RAW == '0) ? DATA_W'(1) : SEED_RAW;

            logic [1:0]        state;
            logic [DATA_W-1:0] val;
            logic              vld;
            logic              done;
            logic [CNT_W-1:0]  cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= ST_IDLE;
                    val   <= '0;
                    vld   <= 1'b0;
                    done  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    case (state)
                        ST_IDLE, ST_DONE: begin
                            if (start) begin
                                val   <= xs_next(SEED);
                                cnt   <= '0;
                                vld   <= 1'b1;
                                done  <= 1'b0;
                                state <= ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            // start is deliberately ignored here, even on the final handshake
                            if (vld && data_rdy[i]) begin
                                if (TRANS_NB != 0 && cnt == CNT_LAST) begin
                                    vld   <= 1'b0;
                                    done  <= 1'b1;
                                    state <= ST_DONE;
                                end else begin
                                    val <= xs_next(val);
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            vld   <= 1'b0;
                        end
                    endcase
                end
            end

            assign data[i*DATA_W +: DATA_W] = val;
            assign data_vld[i]              = vld;
            assign transactions_done[i]     = done;
        end
    endgenerate

    assign all_done = &transactions_done;

endmodule

// File: tb/tb_xorshift_gen_array.sv
// Bench for xorshift_gen_array: 32-bit single channel table, 64-bit 4-channel
// run/backpressure/restart scoreboard, and 32-bit infinite-mode channels.
module tb_xorshift_gen_array;

    localparam int TNA = 4;
    localparam int TNB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 64-bit, 4 channels, 4 transactions
    logic         start_a = 1'b0;
    logic [3:0]   rdy_a = 4'h0;
    logic [3:0]   vld_a;
    logic [255:0] data_a;
    logic [3:0]   done_a;
    logic         all_a;

    // 32-bit, 1 channel, 3 transactions
    logic         start_b = 1'b0;
    logic [0:0]   rdy_b = 1'b0;
    logic [0:0]   vld_b;
    logic [31:0]  data_b;
    logic [0:0]   done_b;
    logic         all_b;

    // 32-bit, 2 channels, infinite mode
    logic         start_c = 1'b0;
    logic [1:0]   rdy_c = 2'b00;
    logic [1:0]   vld_c;
    logic [63:0]  data_c;
    logic [1:0]   done_c;
    logic         all_c;

    xorshift_gen_array #(.CH_NB(4), .DATA_W(64), .TRANS_NB(TNA), .SEED_BASE(64'd0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_rdy(rdy_a), .data_vld(vld_a),
        .data(data_a), .transactions_done(done_a), .all_done(all_a));

    xorshift_gen_array #(.CH_NB(1), .DATA_W(32), .TRANS_NB(TNB), .SEED_BASE(64'd0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_rdy(rdy_b), .data_vld(vld_b),
        .data(data_b), .transactions_done(done_b), .all_done(all_b));

    xorshift_gen_array #(.CH_NB(2), .DATA_W(32), .TRANS_NB(0), .SEED_BASE(64'd5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .data_rdy(rdy_c), .data_vld(vld_c),
        .data(data_c), .transactions_done(done_c), .all_done(all_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_f(input logic [63:0] x_in, input int w);
        logic [63:0] m;
        logic [63:0] x;
        m = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        x = x_in & m;
        if (w == 32) begin
            x = (x ^ (x << 13)) & m;
            x = x ^ (x >> 17);
            x = (x ^ (x << 5)) & m;
        end else begin
            x = x ^ (x << 13);
            x = x ^ (x >> 7);
            x = x ^ (x << 17);
        end
        return x;
    endfunction

    function automatic logic [63:0] ref_nth(input logic [63:0] seed, input int k, input int w);
        logic [63:0] x;
        x = seed;
        for (int j = 0; j < k; j++) x = ref_f(x, w);
        return x;
    endfunction

    function automatic logic [63:0] seed_of(input logic [63:0] base, input int ch, input int w);
        logic [63:0] v;
        v = base + 64'(ch) + 64'd1;
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        if (v == 64'd0) v = 64'd1;
        return v;
    endfunction

    // Model for instance A: values delivered are f^(k+1)(seed), k = handshakes so far.
    bit run_a [4];
    bit dn_a  [4];
    bit st_a  [4];
    int idx_a [4];

    task automatic step_a(input logic st, input logic [3:0] r);
        start_a = st;
        rdy_a   = r;
        for (int ch = 0; ch < 4; ch++) begin
            if (!run_a[ch] && st) begin
                run_a[ch] = 1'b1; dn_a[ch] = 1'b0; st_a[ch] = 1'b1; idx_a[ch] = 0;
            end else if (run_a[ch] && r[ch]) begin
                if (idx_a[ch] + 1 == TNA) begin run_a[ch] = 1'b0; dn_a[ch] = 1'b1; end
                else idx_a[ch]++;
            end
        end
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("a_vld%0d", ch), 64'(vld_a[ch]), 64'(run_a[ch]));
            chk($sformatf("a_done%0d", ch), 64'(done_a[ch]), 64'(dn_a[ch]));
            chk($sformatf("a_data%0d", ch), data_a[ch*64 +: 64],
                st_a[ch] ? ref_nth(seed_of(64'd0, ch, 64), idx_a[ch] + 1, 64) : 64'd0);
        end
        chk("a_all_done", 64'(all_a), 64'(dn_a[0] & dn_a[1] & dn_a[2] & dn_a[3]));
    endtask

    // Model for instance C: never completes, counts handshakes.
    bit run_c [2];
    int idx_c [2];

    task automatic step_c(input logic st, input logic [1:0] r);
        start_c = st;
        rdy_c   = r;
        for (int ch = 0; ch < 2; ch++) begin
            if (!run_c[ch] && st) begin run_c[ch] = 1'b1; idx_c[ch] = 0; end
            else if (run_c[ch] && r[ch]) idx_c[ch]++;
        end
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            chk($sformatf("c_vld%0d", ch), 64'(vld_c[ch]), 64'(run_c[ch]));
            chk($sformatf("c_done%0d", ch), 64'(done_c[ch]), 64'd0);
            chk($sformatf("c_data%0d", ch), 64'(data_c[ch*32 +: 32]),
                run_c[ch] ? ref_nth(seed_of(64'd5, ch, 32), idx_c[ch] + 1, 32) : 64'd0);
        end
        chk("c_all_done", 64'(all_c), 64'd0);
    endtask

    typedef struct {
        logic        start;
        logic        rdy;
        logic        vld;
        logic [31:0] data;
        logic        done;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] s1, s2, s3;
        logic [1:0]  rc;
        logic [3:0]  ra;
        s1 = 32'h0004_2021;
        s2 = 32'h0408_0601;
        s3 = 32'(ref_f(64'(s2), 32));
        // start, rdy -> vld, data, done sampled after the edge
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, s1,    1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, s1,    1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, s1,    1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, s2,    1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, s3,    1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, s3,    1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, s3,    1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, s1,    1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, s2,    1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, s3,    1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_vld", 64'(vld_a), 64'd0);
        chk("rst_a_data", data_a[63:0] | data_a[255:192], 64'd0);
        chk("rst_a_done", 64'({done_a, all_a}), 64'd0);
        chk("rst_b_out", 64'({vld_b, done_b, all_b}), 64'd0);
        chk("rst_b_data", 64'(data_b), 64'd0);
        rst_n = 1'b1;

        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            start_b = tbl[k].start;
            rdy_b   = tbl[k].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("b_vld[%0d]", k), 64'(vld_b), 64'(tbl[k].vld));
            chk($sformatf("b_data[%0d]", k), 64'(data_b), 64'(tbl[k].data));
            chk($sformatf("b_done[%0d]", k), 64'(done_b), 64'(tbl[k].done));
            chk($sformatf("b_all[%0d]", k), 64'(all_b), 64'(tbl[k].done));
        end
        start_b = 1'b0;
        rdy_b   = 1'b0;

        // Reset while channel B is mid-run after two handshakes
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 64'(vld_b), 64'd0);
        chk("midrst_data", 64'(data_b), 64'd0);
        chk("midrst_done", 64'({done_b, all_b}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        chk("postrst_vld", 64'(vld_b), 64'd1);
        chk("postrst_data", 64'(data_b), 64'(s1));

        // Instance A: full run with rdy held high
        step_a(1'b1, 4'hF);
        chk("a_first64", data_a[63:0], 64'h0000_0000_4082_2041);
        for (int k = 0; k < 6; k++) step_a(1'b0, 4'hF);
        chk("a_all_after_run", 64'(all_a), 64'd1);

        // Restart from DONE, channel 1 backpressured, start pulsed during RUN
        step_a(1'b1, 4'b1101);
        for (int k = 0; k < 200 && !(dn_a[0] & dn_a[1] & dn_a[2] & dn_a[3]); k++) begin
            ra = 4'b1101;
            if (k >= 3) ra[1] = 1'($urandom_range(0, 1));
            step_a(k == 1, ra);
        end
        chk("a_bp_all_done", 64'(all_a), 64'd1);
        chk("a_bp_ch1_done", 64'(done_a[1]), 64'd1);

        // Instance C: infinite mode, many more handshakes than the counter range
        step_c(1'b1, 2'b00);
        for (int k = 0; k < 24; k++) begin
            rc = {1'($urandom_range(0, 1)), 1'b1};
            step_c(1'b0, rc);
        end
        chk("c_hs_ch0_gt2", 64'(idx_c[0] > 2), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
